booth_mult: RTL

BOOTH_MULT -- requirements
Module: booth_mult

---
 rtl/booth_mult_if.sv | 20 ++
 rtl/booth_mult.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/booth_mult_if.sv
// Operand/result bundle for booth_mult: start strobe and operands in, registered result out.
// master drives the operands (requester), slave is the multiplier.
interface booth_mult_if;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/booth_mult.sv
// Sequential 32x32 signed Booth multiplier with low-word result and signed-overflow flag.
// Build option MULT_RADIX4_EN: radix-4 modified Booth (16 iterations); otherwise radix-2 (32).
module booth_mult (
    input  logic           clock,
    input  logic           reset,
    booth_mult_if.slave    bus
);
    // state   | meaning
    // IDLE    | waiting for ctrl_MULT, outputs hold last result
    // RUN     | one Booth iteration per cycle
    // DONE    | publish result, pulse data_resultRDY, back to IDLE
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

`ifdef MULT_RADIX4_EN
    localparam logic [4:0] LP_LAST = 5'd15;
`else
    localparam logic [4:0] LP_LAST = 5'd31;
`endif

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [33:0] r_acc;
    logic        r_prev;
    logic [31:0] r_result;
    logic        r_exc;
    logic        r_rdy;

    logic [33:0] w_m_ext;
    logic [33:0] w_addend;
    logic        w_cin;
    logic [33:0] w_sum;
    logic [33:0] w_acc_nxt;
    logic [31:0] w_mplier_nxt;
    logic        w_prev_nxt;
    logic [32:0] w_hi;
    logic        w_ovf;

    // Two guard bits keep +/-2M and the running upper partial product from wrapping.
    assign w_m_ext = {{2{r_mcand[31]}}, r_mcand};

`ifdef MULT_RADIX4_EN
    logic [2:0] w_grp;
    assign w_grp = {r_mplier[1:0], r_prev};

    always_comb begin
        w_addend = '0;
        w_cin    = 1'b0;
        case (w_grp)
            3'b001, 3'b010: w_addend = w_m_ext;
            3'b011:         w_addend = {w_m_ext[32:0], 1'b0};
            3'b100: begin
                w_addend = ~{w_m_ext[32:0], 1'b0};
                w_cin    = 1'b1;
            end
            3'b101, 3'b110: begin
                w_addend = ~w_m_ext;
                w_cin    = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_sum        = r_acc + w_addend + {33'd0, w_cin};
    assign w_acc_nxt    = {{2{w_sum[33]}}, w_sum[33:2]};
    assign w_mplier_nxt = {w_sum[1:0], r_mplier[31:2]};
    assign w_prev_nxt   = r_mplier[1];
`else
    always_comb begin
        w_addend = '0;
        w_cin    = 1'b0;
        case ({r_mplier[0], r_prev})
            2'b01: w_addend = w_m_ext;
            2'b10: begin
                w_addend = ~w_m_ext;
                w_cin    = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_sum        = r_acc + w_addend + {33'd0, w_cin};
    assign w_acc_nxt    = {w_sum[33], w_sum[33:1]};
    assign w_mplier_nxt = {w_sum[0], r_mplier[31:1]};
    assign w_prev_nxt   = r_mplier[0];
`endif

    // Product bits 63..31; overflow when they are not a pure sign extension.
    assign w_hi  = {r_acc[31:0], r_mplier[31]};
    assign w_ovf = ~((&w_hi) | ~(|w_hi));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_prev   <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else if (bus.ctrl_MULT) begin
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_mcand  <= bus.data_operandA;
            r_mplier <= bus.data_operandB;
            r_acc    <= '0;
            r_prev   <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_mplier <= w_mplier_nxt;
                    r_prev   <= w_prev_nxt;
                    r_cnt    <= r_cnt + 5'd1;
                    r_rdy    <= 1'b0;
                    if (r_cnt == LP_LAST) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_result <= r_mplier;
                    r_exc    <= w_ovf;
                    r_rdy    <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_rdy   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
endmodule
